// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage bundles and defaults for pipe_ctrl.
// Optional build macro used by the block: PIPE_CTRL_FWD_EN.
package pipe_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NSTAGES_DEF  = 5;
  localparam int BR_STAGE_DEF = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  is_load;
    logic                  is_branch;
  } stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic                  rs1_use;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs2_use;
  } src_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register pending counters and hazard compare.
// PIPE_CTRL_FWD_EN narrows the stall to load-use only.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en,
  input  logic [REG_ADDR_W-1:0] inc_rd,
  input  logic                  dec_en,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  chk_v,
  input  src_t                  src,
`ifdef PIPE_CTRL_FWD_EN
  input  logic                  ld_v,
  input  logic [REG_ADDR_W-1:0] ld_rd,
`endif
  output logic                  dep_stall
);

  localparam int CW   = $clog2(NSTAGES) + 1;
  localparam int NREG = 1 << REG_ADDR_W;

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic          hit1;
  logic          hit2;

  // Count up on issue, down on commit; both at once cancel; x0 stays 0.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        unique case ({inc_en && (inc_rd == REG_ADDR_W'(r)),
                      dec_en && (dec_rd == REG_ADDR_W'(r))})
          2'b10:   cnt_d[r] = cnt_q[r] + CW'(1);
          2'b01:   cnt_d[r] = cnt_q[r] - CW'(1);
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  assign hit1 = src.rs1_use && ld_v && (src.rs1 == ld_rd);
  assign hit2 = src.rs2_use && ld_v && (src.rs2 == ld_rd);
`else
  assign hit1 = src.rs1_use && (cnt_q[src.rs1] != '0);
  assign hit2 = src.rs2_use && (cnt_q[src.rs2] != '0);
`endif

  assign dep_stall = chk_v && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline valid/stall/redirect control.
// Build option: PIPE_CTRL_FWD_EN (load-use stall only).
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGES  = NSTAGES_DEF,
  parameter int XLEN     = 64,
  parameter int BR_STAGE = BR_STAGE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fe_valid,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_rs1_use,
  input  logic                  de_rs2_use,
  input  logic [REG_ADDR_W-1:0] de_rd,
  input  logic                  de_wen,
  input  logic                  de_is_load,
  input  logic                  de_is_branch,
  input  logic                  br_taken,
  input  logic [XLEN-1:0]       br_target,
  output logic [NSTAGES-1:0]    stage_v,
  output logic                  fe_stall,
  output logic                  dep_stall,
  output logic                  br_stall,
  output logic                  pc_mux,
  output logic [XLEN-1:0]       pc_target,
  output logic                  wb_commit,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  stage_t [NSTAGES-1:0] stg_q;
  stage_t [NSTAGES-1:0] stg_d;
  src_t                 src_q;
  src_t                 src_d;
  logic                 br_blk;
  logic                 issue;
  logic                 unused_tail;

  // Branches in flight up to the resolve stage block issue.
  always_comb begin
    br_blk = 1'b0;
    for (int s = 1; s <= BR_STAGE; s++) begin
      br_blk |= stg_q[s].valid & stg_q[s].is_branch;
    end
  end

  // A branch in decode still issues itself; it only holds fetch.
  assign br_stall = br_blk
                  | (stg_q[0].valid & stg_q[0].is_branch);
  assign fe_stall = dep_stall | br_stall;
  assign issue    = stg_q[0].valid & ~dep_stall & ~br_blk;

  // Decode load/hold, bubble insert and free-running shift.
  always_comb begin
    stg_d = stg_q;
    src_d = src_q;
    if (!fe_stall) begin
      stg_d[0] = '{valid:     fe_valid,
                   rd:        de_rd,
                   wen:       de_wen,
                   is_load:   de_is_load,
                   is_branch: de_is_branch};
      src_d    = '{rs1:     de_rs1,
                   rs1_use: de_rs1_use,
                   rs2:     de_rs2,
                   rs2_use: de_rs2_use};
    end else if (issue) begin
      stg_d[0].valid = 1'b0;
    end
    stg_d[1] = issue ? stg_q[0] : '0;
    for (int s = 2; s < NSTAGES; s++) begin
      stg_d[s] = stg_q[s-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
      src_q <= '0;
    end else begin
      stg_q <= stg_d;
      src_q <= src_d;
    end
  end

  // Per-stage valid fan-out.
  always_comb begin
    for (int s = 0; s < NSTAGES; s++) begin
      stage_v[s] = stg_q[s].valid;
    end
  end

  assign pc_mux    = br_taken
                   & stg_q[BR_STAGE].valid
                   & stg_q[BR_STAGE].is_branch;
  assign pc_target = pc_mux ? br_target : '0;

  assign wb_commit = stg_q[NSTAGES-1].valid
                   & stg_q[NSTAGES-1].wen
                   & (stg_q[NSTAGES-1].rd != '0);
  assign wb_rd     = stg_q[NSTAGES-1].rd;

  assign unused_tail = ^{stg_q[NSTAGES-1].is_load,
                         stg_q[NSTAGES-1].is_branch};

  pipe_scoreboard #(.NSTAGES(NSTAGES)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (issue & stg_q[0].wen),
    .inc_rd    (stg_q[0].rd),
    .dec_en    (wb_commit),
    .dec_rd    (wb_rd),
    .chk_v     (stg_q[0].valid),
    .src       (src_q),
`ifdef PIPE_CTRL_FWD_EN
    .ld_v      (stg_q[1].valid & stg_q[1].is_load),
    .ld_rd     (stg_q[1].rd),
`endif
    .dep_stall (dep_stall)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a timing model.
// Build with or without PIPE_CTRL_FWD_EN.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int N  = 5;
  localparam int BR = 2;
  localparam int XL = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fe_valid;
  logic [4:0]    de_rs1, de_rs2, de_rd;
  logic          de_rs1_use, de_rs2_use;
  logic          de_wen, de_is_load, de_is_branch;
  logic          br_taken;
  logic [XL-1:0] br_target;
  logic [N-1:0]  stage_v;
  logic          fe_stall, dep_stall, br_stall;
  logic          pc_mux, wb_commit;
  logic [XL-1:0] pc_target;
  logic [4:0]    wb_rd;

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGES(N), .XLEN(XL), .BR_STAGE(BR)) dut (
    .clk(clk), .rst_n(rst_n), .fe_valid(fe_valid),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_use(de_rs1_use), .de_rs2_use(de_rs2_use),
    .de_rd(de_rd), .de_wen(de_wen),
    .de_is_load(de_is_load), .de_is_branch(de_is_branch),
    .br_taken(br_taken), .br_target(br_target),
    .stage_v(stage_v), .fe_stall(fe_stall),
    .dep_stall(dep_stall), .br_stall(br_stall),
    .pc_mux(pc_mux), .pc_target(pc_target),
    .wb_commit(wb_commit), .wb_rd(wb_rd)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wen, ld, br;
  } ins_t;
  typedef struct { ins_t in; int i; } fl_t;
  typedef struct { logic [4:0] rd; int due; } ex_t;

  ins_t dslot;
  ins_t idle_i;
  fl_t  fl[$];
  ex_t  expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   ds_cnt, bs_cnt, pm_cnt;
  logic [XL-1:0] last_tgt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic hits(ins_t d, logic [4:0] r);
    return (d.u1 && d.rs1 == r) || (d.u2 && d.rs2 == r);
  endfunction

  function automatic ins_t mk(logic [4:0] rd, logic wen, logic ld,
                              logic br, logic [4:0] rs1, logic u1);
    ins_t r = '{default: 0};
    r.v = 1'b1; r.rd = rd; r.wen = wen; r.ld = ld;
    r.br = br; r.rs1 = rs1; r.u1 = u1;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r;
    r.v   = ($urandom_range(9) < 8);
    r.rs1 = 5'($urandom_range(7));
    r.rs2 = 5'($urandom_range(7));
    r.u1  = 1'($urandom_range(1));
    r.u2  = 1'($urandom_range(1));
    r.rd  = 5'($urandom_range(7));
    r.wen = ($urandom_range(3) != 0);
    r.ld  = ($urandom_range(3) == 0);
    r.br  = !r.ld && ($urandom_range(9) == 0);
    if (r.ld) begin
      r.wen = 1'b1;
      if (r.rd == 0) r.rd = 5'd1;
    end
    if (r.br) r.wen = 1'b0;
    return r;
  endfunction

  task automatic drive(ins_t f, logic bt, logic [XL-1:0] tg);
    fe_valid = f.v; de_rs1 = f.rs1; de_rs2 = f.rs2;
    de_rs1_use = f.u1; de_rs2_use = f.u2; de_rd = f.rd;
    de_wen = f.wen; de_is_load = f.ld; de_is_branch = f.br;
    br_taken = bt; br_target = tg;
  endtask

  task automatic cycle(ins_t f, logic bt, logic [XL-1:0] tg,
                       output logic acc);
    logic dep, bst, bblk, iss, pm, fes;
    logic [N-1:0] sv;
    int age;
    @(posedge clk);
    cyc++;
    #1 drive(f, bt, tg);
    #1;
    dep = 0; bblk = 0; pm = 0; sv = '0;
    sv[0] = dslot.v;
    bst = dslot.v && dslot.br;
    foreach (fl[k]) begin
      age = cyc - fl[k].i;
      if (age >= 1 && age <= N-1) begin
        sv[age] = 1'b1;
        if (age <= BR && fl[k].in.br) begin
          bst = 1; bblk = 1;
        end
        if (age == BR && fl[k].in.br && bt) pm = 1;
`ifdef PIPE_CTRL_FWD_EN
        if (age == 1 && fl[k].in.ld && hits(dslot, fl[k].in.rd))
          dep = 1;
`else
        if (fl[k].in.wen && fl[k].in.rd != 0 &&
            hits(dslot, fl[k].in.rd))
          dep = 1;
`endif
      end
    end
    dep = dep && dslot.v;
    iss = dslot.v && !dep && !bblk;
    fes = dep || bst;
    chk("stage_v", 64'(stage_v), 64'(sv));
    chk("dep_stall", 64'(dep_stall), 64'(dep));
    chk("br_stall", 64'(br_stall), 64'(bst));
    chk("fe_stall", 64'(fe_stall), 64'(fes));
    chk("pc_mux", 64'(pc_mux), 64'(pm));
    chk("pc_target", pc_target, pm ? tg : 64'd0);
    if (dep_stall) ds_cnt++;
    if (br_stall) bs_cnt++;
    if (pc_mux) begin pm_cnt++; last_tgt = pc_target; end
    if (iss) begin
      fl.push_back('{dslot, cyc});
      if (dslot.wen && dslot.rd != 0)
        expq.push_back('{dslot.rd, cyc + N - 1});
    end
    if (!fes) dslot = f;
    else if (iss) dslot.v = 1'b0;
    while (fl.size() > 0 && cyc - fl[0].i >= N - 1)
      void'(fl.pop_front());
    acc = f.v && !fes;
  endtask

  task automatic feed(ins_t f, logic bt, logic [XL-1:0] tg);
    logic acc;
    for (int k = 0; k < 40; k++) begin
      cycle(f, bt, tg, acc);
      if (acc) return;
    end
    chk("feed_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(int n, logic bt, logic [XL-1:0] tg);
    logic acc;
    repeat (n) cycle(idle_i, bt, tg, acc);
  endtask

  task automatic zero_chk(string nm);
    chk({nm, "_v"}, 64'(stage_v), 64'd0);
    chk({nm, "_fes"}, 64'(fe_stall), 64'd0);
    chk({nm, "_dep"}, 64'(dep_stall), 64'd0);
    chk({nm, "_brs"}, 64'(br_stall), 64'd0);
    chk({nm, "_pcm"}, 64'(pc_mux), 64'd0);
    chk({nm, "_pct"}, pc_target, 64'd0);
    chk({nm, "_wbc"}, 64'(wb_commit), 64'd0);
    chk({nm, "_wbr"}, 64'(wb_rd), 64'd0);
  endtask

  task automatic release_rst();
    ins_t p;
    p = mk(5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    drive(p, 1'b0, '0);
    dslot = p;
    rst_n = 1'b1;
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    fl.delete(); expq.delete();
    dslot = idle_i;
    drive(idle_i, 1'b1, '1);
    #1 zero_chk("midrst");
    @(posedge clk);
    #1 release_rst();
  endtask

  initial begin : mon
    ex_t ex;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wb_commit) begin
          if (expq.size() == 0) begin
            chk("wb_unexpected", 64'd1, 64'd0);
          end else begin
            ex = expq.pop_front();
            chk("wb_rd", 64'(wb_rd), 64'(ex.rd));
            chk("wb_cycle", 64'(cyc), 64'(ex.due));
          end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
          chk("wb_missing", 64'd0, 64'd1);
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin : drv
    ins_t cur;
    logic acc;
    int   exp_a, exp_b, exp_d;
`ifdef PIPE_CTRL_FWD_EN
    exp_a = 0; exp_b = 1; exp_d = 0;
`else
    exp_a = 4; exp_b = 4; exp_d = 4;
`endif
    idle_i = '{default: 0};
    dslot = idle_i;
    drive(idle_i, 1'b1, '1);
    repeat (2) @(posedge clk);
    #1 zero_chk("rst");
    release_rst();

    ds_cnt = 0; pm_cnt = 0;
    feed(mk(5'd5, 1, 0, 0, 5'd0, 0), 1'b1, 64'h2000);
    feed(mk(5'd0, 0, 0, 0, 5'd5, 1), 1'b1, 64'h2000);
    idle(8, 1'b1, 64'h2000);
    chk("raw_alu_stalls", 64'(ds_cnt), 64'(exp_a));
    chk("br_taken_ignored", 64'(pm_cnt), 64'd0);

    ds_cnt = 0;
    feed(mk(5'd5, 1, 1, 0, 5'd0, 0), 1'b0, '0);
    feed(mk(5'd0, 0, 0, 0, 5'd5, 1), 1'b0, '0);
    idle(8, 1'b0, '0);
    chk("raw_load_stalls", 64'(ds_cnt), 64'(exp_b));

    bs_cnt = 0; pm_cnt = 0; last_tgt = '0;
    feed(mk(5'd0, 0, 0, 1, 5'd0, 0), 1'b1, 64'h1000);
    idle(8, 1'b1, 64'h1000);
    chk("br_stall_cycles", 64'(bs_cnt), 64'(BR + 1));
    chk("pc_mux_cycles", 64'(pm_cnt), 64'd1);
    chk("pc_target_dir", last_tgt, 64'h1000);

    ds_cnt = 0;
    feed(mk(5'd7, 1, 0, 0, 5'd0, 0), 1'b0, '0);
    for (int r = 1; r <= 3; r++)
      feed(mk(5'(r), 1, 0, 0, 5'd0, 0), 1'b0, '0);
    feed(mk(5'd7, 1, 0, 0, 5'd0, 0), 1'b0, '0);
    feed(mk(5'd0, 0, 0, 0, 5'd7, 1), 1'b0, '0);
    idle(8, 1'b0, '0);
    chk("x7_same_cycle", 64'(ds_cnt), 64'(exp_d));

    for (int r = 1; r <= 6; r++)
      feed(mk(5'(r), 1, 0, 0, 5'd0, 0), 1'b0, '0);
    mid_reset();
    for (int r = 1; r <= 6; r++)
      feed(mk(5'd0, 0, 0, 0, 5'(r), 1), 1'b0, '0);
    idle(6, 1'b0, '0);

    cur = rnd_ins();
    repeat (400) begin
      cycle(cur, 1'($urandom_range(1)), {$urandom, $urandom}, acc);
      if (acc || !cur.v) cur = rnd_ins();
    end
    mid_reset();
    cur = rnd_ins();
    repeat (600) begin
      cycle(cur, 1'($urandom_range(1)), {$urandom, $urandom}, acc);
      if (acc || !cur.v) cur = rnd_ins();
    end
    idle(12, 1'b0, '0);
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
